// File: rtl/duty_ramp.sv
// Slew-limited duty generator feeding the 11-bit PWM stage. Converts a signed
// speed command to offset-binary duty and ramps it once per 2048-cycle period.
//
// state | meaning
// IDLE  | duty parked at midpoint (1024), waiting for en without brake
// RUN   | on each period boundary, step duty toward clipped speed target
// STOP  | on each period boundary, step duty toward 1024, then return to IDLE
module duty_ramp #(
   parameter int STEP      = 8,
   parameter int STOP_STEP = 32,
   parameter int DUTY_MIN  = 64,
   parameter int DUTY_MAX  = 1983
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               brake,
   input  logic signed [11:0] spd,
   output logic        [10:0] duty,
   output logic               upd,
   output logic               at_tgt,
   output logic               busy
);

   typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

   localparam logic        [10:0] MID   = 11'd1024;
   localparam logic signed [12:0] MIN13 = 13'(DUTY_MIN);
   localparam logic signed [12:0] MAX13 = 13'(DUTY_MAX);

   state_t             state;
   logic        [10:0] pcnt;
   logic               bnd;
   logic signed [12:0] spd_ext;
   logic signed [12:0] tgt_raw;
   logic        [10:0] tgt;
   logic        [10:0] run_next;
   logic        [10:0] stop_next;

   // Moves cur toward t by at most s; lands exactly on t when within reach.
   function automatic logic [10:0] step_to(input logic [10:0] cur,
                                           input logic [10:0] t,
                                           input logic [10:0] s);
      logic signed [11:0] d;
      logic        [11:0] mag;
      d   = $signed({1'b0, t}) - $signed({1'b0, cur});
      mag = d[11] ? 12'(-d) : 12'(d);
      if (mag <= {1'b0, s})
         return t;
      else if (!d[11])
         return cur + s;
      else
         return cur - s;
   endfunction

   assign bnd = (pcnt == 11'h7ff);
   assign upd = bnd;

   // Arithmetic shift floors toward -inf, so spd=-1 maps to 1023.
   always_comb begin
      spd_ext = 13'(spd);
      tgt_raw = 13'sd1024 + (spd_ext >>> 1);
      if (tgt_raw < MIN13)
         tgt = MIN13[10:0];
      else if (tgt_raw > MAX13)
         tgt = MAX13[10:0];
      else
         tgt = tgt_raw[10:0];
   end

   assign run_next  = step_to(duty, tgt, 11'(STEP));
   assign stop_next = step_to(duty, MID, 11'(STOP_STEP));

   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt   <= 11'd0;
         state  <= IDLE;
         duty   <= MID;
         at_tgt <= 1'b0;
         busy   <= 1'b0;
      end else begin
         pcnt <= pcnt + 11'd1;
         case (state)
            IDLE: begin
               duty   <= MID;
               at_tgt <= 1'b0;
               if (en && !brake) begin
                  state <= RUN;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               // Exit wins over a coincident boundary step.
               if (!en || brake) begin
                  state  <= STOP;
                  at_tgt <= 1'b0;
               end else if (bnd) begin
                  duty   <= run_next;
                  at_tgt <= (run_next == tgt);
               end
            end
            STOP: begin
               if (bnd) begin
                  duty <= stop_next;
                  if (stop_next == MID) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
